// File: rtl/slow_fil.sv
// slow_fil: resource-lean FIR filter with one shared signed multiplier.
// Each accepted sample starts an NTAPS-cycle multiply-accumulate pass over the
// tap memory and a circular sample history. The pass yields one output word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_ce; accepts a sample and starts a pass
// S_READ  | reading tap[k] / x[n-k] for k = 0..NTAPS-1, one per clock
// S_DRAIN | multiply and accumulate stages flushing; result published on exit
module slow_fil #(
   parameter int NTAPS   = 103,
   parameter int LGNTAPS = 7,
   parameter int IW      = 16,
   parameter int TW      = 16,
   parameter int OW      = IW + TW + LGNTAPS
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_tap_wr,
   input  logic [TW-1:0] i_tap,
   input  logic          i_ce,
   input  logic [IW-1:0] i_sample,
   output logic [OW-1:0] o_result,
   output logic          o_ce
);

   localparam int PW = IW + TW;
   localparam logic [LGNTAPS-1:0] LAST_IDX = LGNTAPS'(NTAPS - 1);
   localparam logic [LGNTAPS-1:0] FULL_CNT = LGNTAPS'(NTAPS);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t state, state_nx;
   logic   accept;
   logic   rd_en;

   logic signed [TW-1:0] tap_mem  [NTAPS];
   logic signed [IW-1:0] hist_mem [NTAPS];

   logic [LGNTAPS-1:0] twidx;
   logic [LGNTAPS-1:0] dwidx;
   logic [LGNTAPS-1:0] fill;
   logic [LGNTAPS-1:0] ridx;
   logic [LGNTAPS-1:0] k;

   logic signed [TW-1:0] r_tap;
   logic signed [IW-1:0] r_x;
   logic                 rd_v, rd_last;
   logic signed [PW-1:0] prod;
   logic                 prod_v, prod_last;
   logic signed [OW-1:0] acc;
   logic                 acc_last;

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next-state logic; the pass ends once the final product has been accumulated.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      rd_en    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (i_ce) begin
               accept   = 1'b1;
               state_nx = S_READ;
            end
         end
         S_READ: begin
            rd_en = 1'b1;
            if (k == LAST_IDX) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (acc_last) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Tap and history storage; not reset, the fill count masks stale history.
   always_ff @(posedge i_clk) begin
      if (i_tap_wr) tap_mem[twidx] <= i_tap;
      if (accept)   hist_mem[dwidx] <= i_sample;
   end

   // Write pointers, fill count and the read index walking backwards in time.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         twidx <= '0;
         dwidx <= '0;
         fill  <= '0;
         ridx  <= '0;
         k     <= '0;
      end else begin
         if (i_tap_wr) twidx <= (twidx == LAST_IDX) ? '0 : twidx + 1'b1;
         if (accept) begin
            dwidx <= (dwidx == LAST_IDX) ? '0 : dwidx + 1'b1;
            if (fill != FULL_CNT) fill <= fill + 1'b1;
            ridx  <= dwidx;
            k     <= '0;
         end else if (rd_en) begin
            k    <= k + 1'b1;
            ridx <= (ridx == '0) ? LAST_IDX : ridx - 1'b1;
         end
      end
   end

   // Read, multiply and accumulate pipeline stages.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tap     <= '0;
         r_x       <= '0;
         rd_v      <= 1'b0;
         rd_last   <= 1'b0;
         prod      <= '0;
         prod_v    <= 1'b0;
         prod_last <= 1'b0;
         acc       <= '0;
         acc_last  <= 1'b0;
      end else begin
         r_tap     <= tap_mem[k];
         r_x       <= (k < fill) ? hist_mem[ridx] : '0;
         rd_v      <= rd_en;
         rd_last   <= rd_en && (k == LAST_IDX);
         prod      <= r_tap * r_x;
         prod_v    <= rd_v;
         prod_last <= rd_last;
         if (accept)      acc <= '0;
         else if (prod_v) acc <= acc + {{(OW-PW){prod[PW-1]}}, prod};
         acc_last  <= prod_v && prod_last;
      end
   end

   // Publish the finished sum with a one-cycle strobe.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_result <= '0;
         o_ce     <= 1'b0;
      end else begin
         if (acc_last) o_result <= acc;
         o_ce <= acc_last;
      end
   end

endmodule

// File: tb/tb_slow_fil.sv
// tb_slow_fil: directed and randomized checks of slow_fil against a
// sum-of-products reference built from a tap array and a sample queue.
module tb_slow_fil;

   localparam int NTAPS = 103;
   localparam int IW    = 16;
   localparam int TW    = 16;
   localparam int OW    = 39;
   localparam int LAT   = NTAPS + 3;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_tap_wr;
   logic [TW-1:0] i_tap;
   logic          i_ce;
   logic [IW-1:0] i_sample;
   logic [OW-1:0] o_result;
   logic          o_ce;

   int     tests = 0;
   int     fails = 0;
   int     mtap [NTAPS];
   int     mtw = 0;
   int     hist [$];
   longint last_obs;

   slow_fil dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_tap_wr (i_tap_wr),
      .i_tap    (i_tap),
      .i_ce     (i_ce),
      .i_sample (i_sample),
      .o_result (o_result),
      .o_ce     (o_ce)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_y();
      longint s = 0;
      int     n = hist.size();
      for (int j = 0; j < NTAPS && j < n; j++)
         s += longint'(mtap[j]) * longint'(hist[n-1-j]);
      return s;
   endfunction

   function automatic longint res_s();
      return longint'($signed(o_result));
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic do_reset();
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      mtw = 0;
      hist.delete();
   endtask

   task automatic write_tap(input logic [TW-1:0] v);
      i_tap_wr = 1'b1;
      i_tap    = v;
      mtap[mtw] = int'($signed(v));
      mtw = (mtw + 1) % NTAPS;
      @(negedge i_clk);
      i_tap_wr = 1'b0;
   endtask

   task automatic push_hist(input logic [IW-1:0] x);
      hist.push_back(int'($signed(x)));
      if (hist.size() > NTAPS) void'(hist.pop_front());
   endtask

   task automatic send_sample(input string tag, input logic [IW-1:0] x,
                              input bit tw = 1'b0, input logic [TW-1:0] tv = '0);
      int     cyc;
      longint exp;
      i_ce     = 1'b1;
      i_sample = x;
      if (tw) begin
         i_tap_wr = 1'b1;
         i_tap    = tv;
         mtap[mtw] = int'($signed(tv));
         mtw = (mtw + 1) % NTAPS;
      end
      @(negedge i_clk);
      i_ce     = 1'b0;
      i_tap_wr = 1'b0;
      push_hist(x);
      exp = model_y();
      cyc = 0;
      while (o_ce !== 1'b1 && cyc < 200) begin
         @(negedge i_clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, LAT);
      last_obs = res_s();
      check({tag, " value"}, last_obs, exp);
      @(negedge i_clk);
      check({tag, " single pulse"}, longint'(o_ce), 0);
   endtask

   initial begin
      int     pulses;
      int     pcyc;
      longint pval;
      longint exp;

      i_reset  = 1'b1;
      i_tap_wr = 1'b0;
      i_tap    = '0;
      i_ce     = 1'b0;
      i_sample = '0;
      repeat (2) @(negedge i_clk);
      check("reset o_result", res_s(), 0);
      check("reset o_ce", longint'(o_ce), 0);
      i_reset = 1'b0;
      mtw = 0;
      @(negedge i_clk);

      // Impulse response through taps k+1.
      for (int j = 0; j < NTAPS; j++) write_tap(TW'(j + 1));
      do_reset();
      send_sample("impulse", IW'(1));
      check("impulse first", last_obs, 1);
      for (int j = 1; j < NTAPS; j++) send_sample($sformatf("impulse[%0d]", j), '0);
      check("impulse last", last_obs, NTAPS);

      // DC gain ramps then saturates at NTAPS.
      do_reset();
      for (int j = 0; j < NTAPS; j++) write_tap(TW'(1));
      for (int j = 0; j < NTAPS + 7; j++) send_sample($sformatf("dc[%0d]", j), IW'(1));
      check("dc steady", last_obs, NTAPS);

      // Most-negative extremes: largest positive sum, no wrap.
      do_reset();
      for (int j = 0; j < NTAPS; j++) write_tap(16'h8000);
      for (int j = 0; j < NTAPS; j++) send_sample($sformatf("ext_neg[%0d]", j), 16'h8000);
      check("ext_neg steady", last_obs, 64'sd110595407872);
      for (int j = 0; j < NTAPS; j++) write_tap(16'h7FFF);
      send_sample("ext_mix", 16'h8000);
      check("ext_mix steady", last_obs, longint'(-103) * 32767 * 32768);

      // Tap write pointer wraps: 104th write lands on tap[0].
      do_reset();
      for (int j = 0; j < NTAPS; j++) write_tap('0);
      write_tap(TW'(5));
      send_sample("wrap0", IW'(1));
      check("wrap first", last_obs, 5);
      for (int j = 1; j < 4; j++) send_sample($sformatf("wrap[%0d]", j), '0);

      // Random taps and samples, one tap write coinciding with the accept.
      do_reset();
      for (int j = 0; j < NTAPS; j++) write_tap(TW'($urandom_range(0, 65535)));
      for (int j = 0; j < 25; j++) begin
         if (j == 5)
            send_sample($sformatf("rand[%0d]", j), IW'($urandom_range(0, 65535)),
                        1'b1, TW'($urandom_range(0, 65535)));
         else
            send_sample($sformatf("rand[%0d]", j), IW'($urandom_range(0, 65535)));
      end

      // Overrun: a second i_ce 10 clocks into a pass is dropped.
      i_ce     = 1'b1;
      i_sample = IW'($urandom_range(0, 65535));
      @(negedge i_clk);
      i_ce = 1'b0;
      push_hist(i_sample);
      exp    = model_y();
      pulses = 0;
      pcyc   = -1;
      pval   = 0;
      for (int c = 1; c <= LAT + 8; c++) begin
         if (c == 10) i_ce = 1'b1;
         if (c == 10) i_sample = IW'($urandom_range(0, 65535));
         @(negedge i_clk);
         i_ce = 1'b0;
         if (o_ce === 1'b1) begin
            pulses++;
            if (pcyc < 0) begin
               pcyc = c;
               pval = res_s();
            end
         end
      end
      check("busy pulses", pulses, 1);
      check("busy latency", pcyc, LAT);
      check("busy value", pval, exp);
      send_sample("after busy", IW'($urandom_range(0, 65535)));

      // Reset mid-pass aborts the computation; taps survive.
      i_ce     = 1'b1;
      i_sample = IW'($urandom_range(1, 65535));
      @(negedge i_clk);
      i_ce = 1'b0;
      repeat (50) @(negedge i_clk);
      i_reset = 1'b1;
      #1;
      check("midreset o_result", res_s(), 0);
      check("midreset o_ce", longint'(o_ce), 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      mtw = 0;
      hist.delete();
      pulses = 0;
      for (int c = 0; c < LAT + 10; c++) begin
         @(negedge i_clk);
         if (o_ce === 1'b1) pulses++;
      end
      check("midreset no pulse", pulses, 0);
      check("midreset held", res_s(), 0);
      send_sample("post reset", IW'($urandom_range(0, 65535)));
      send_sample("post reset2", IW'($urandom_range(0, 65535)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/slow_fil.md
Name: slow_fil

Overview:
- Resource-lean FIR filter: one signed 16x16 multiplier, evaluating one tap product per clock.
- Taps load serially into an internal tap memory; input samples go into a circular history buffer.
- Each accepted sample triggers a full NTAPS-cycle multiply-accumulate pass that produces one output word.
- Sits under filter_control, which streams the coefficient set in via i_tap_wr/i_tap after start.

Parameters:
NTAPS, 103, number of filter taps (tap memory and sample history depth)
LGNTAPS, 7, index width, ceil(log2(NTAPS))
IW, 16, input sample width (signed)
TW, 16, tap coefficient width (signed)
OW, 39, output width = IW+TW+LGNTAPS

Ports:
i_clk  input  1  clock, all state changes on rising edge
i_reset  input  1  asynchronous, active-high reset
i_tap_wr  input  1  write i_tap into tap memory at the tap write pointer
i_tap  input  TW  signed tap coefficient
i_ce  input  1  sample strobe: accept i_sample and start a computation
i_sample  input  IW  signed input sample
o_result  output  OW  signed filter output, registered
o_ce  output  1  one-cycle pulse when o_result updates (may be left unconnected)

Behaviour:
- Reset (async) clears: tap write pointer, sample write pointer, history fill count, busy flag, tap/sample counters, pipeline registers, accumulator, o_result=0, o_ce=0.
- Reset does not clear tap memory. Tap memory is zero at power-up.
- Tap load: on each clock with i_tap_wr=1, write tap[twidx] <= i_tap, then twidx <= twidx+1, wrapping NTAPS-1 -> 0.
- Tap writes are accepted while busy. A computation in flight uses whatever tap values it reads.
- Sample accept: on a clock with i_ce=1 and not busy:
  - write x into history at dwidx, advance dwidx (wrap at NTAPS);
  - increment fill count, saturating at NTAPS;
  - set busy, zero the accumulator, set k=0.
- i_ce while busy is ignored: sample dropped, no state change.
- Simultaneous i_tap_wr and i_ce are both honoured.
- Computation: y[n] = sum over k=0..NTAPS-1 of tap[k]*x[n-k], where x[n] is the sample just accepted.
- History entries with k >= fill count (older than reset) read as 0.
- Pipeline timing, with cycle 0 = the accepting edge:
  - cycles 1..NTAPS: read tap[k] and x[n-k];
  - next cycle: register the 32-bit signed product;
  - next cycle: add it to the accumulator, sign-extended to OW.
- o_result <= accumulator and o_ce=1 for exactly one cycle at edge NTAPS+3 after the accepting edge. Busy clears on that same edge, so a new i_ce can be accepted on the following edge.
- o_result holds between updates.
- Arithmetic is two's complement throughout, with no rounding or saturation. OW=39 cannot overflow: 103*2^30 < 2^38.
- Reset mid-computation aborts it: no o_ce pulse, o_result=0.

Test Plan:
- Impulse: load taps tap[k]=k+1 (103 writes); after reset send x=1, then 102 zeros, each spaced NTAPS+4 clocks -> outputs 1,2,3,...,103 in order, each with a single o_ce pulse at NTAPS+3 clocks after i_ce.
- DC gain: all taps 1, all samples 1 -> outputs 1,2,...,103, then 103 for every further sample.
- Extremes: all taps 0x8000, all samples 0x8000 -> steady-state o_result = 110595407872 (positive, no wrap); taps 0x7FFF with samples 0x8000 -> -103*32767*32768.
- Tap pointer wrap: write 104 taps, the last being 5, others 0 -> impulse of 1 yields first output 5, next 102 outputs 0.
- Busy/overrun: assert i_ce again 10 clocks after an accepted sample -> second sample ignored, exactly one o_ce, history advances by one.
- Reset mid-pass: assert i_reset 50 clocks into a computation -> o_result=0, no o_ce; next accepted sample computes as the first sample after reset (older history treated as 0, taps retained).
